// File: rtl/mux_scan.sv
// Channel multiplexer with manual select and timed automatic scan.
// ch/dout are registered; ch_chg flags the cycle after ch takes a new value.
module mux_scan #(
    parameter  int CH_NUM = 4,
    parameter  int DATA_W = 1,
    parameter  int DWELL  = 12_000_000,
    localparam int SEL_W  = $clog2(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM*DATA_W-1:0] din,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     hold,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         ch,
    output logic                     ch_chg
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CH_NUM - 1);
    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CH_NUM);

    typedef enum logic [1:0] {MANUAL, SCAN, PAUSE} state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [SEL_W-1:0]             ch_nxt;
    logic [CH_NUM-1:0][DATA_W-1:0] din_a;
    logic                         sel_ok;

    assign din_a  = din;
    assign sel_ok = ({1'b0, sel} < CH_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MANUAL;
            cnt    <= '0;
            ch     <= '0;
            dout   <= '0;
            ch_chg <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ch     <= ch_nxt;
            dout   <= din_a[ch_nxt];
            ch_chg <= (ch_nxt != ch);
        end
    end

    // A hold edge in SCAN already freezes; the PAUSE->SCAN edge does not count,
    // so the frozen count resumes on the first full SCAN cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        if (!mode) begin
            state_nxt = MANUAL;
            cnt_nxt   = '0;
            if (sel_ok)
                ch_nxt = sel;
        end else begin
            case (state)
                MANUAL: begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end
                SCAN: begin
                    if (hold) begin
                        state_nxt = PAUSE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        ch_nxt  = (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                PAUSE: begin
                    if (!hold)
                        state_nxt = SCAN;
                end
                default: state_nxt = MANUAL;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: per-edge vector table on a 4-channel instance,
// plus hand sequences for async reset and a 3-channel instance.
module tb_mux_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic       mode, hold;
    logic [1:0] sel;
    logic       dout;
    logic [1:0] ch;
    logic       ch_chg;

    logic [2:0] din3;
    logic       mode3, hold3;
    logic [1:0] sel3;
    logic       dout3;
    logic [1:0] ch3;
    logic       ch_chg3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_scan #(.CH_NUM(4), .DATA_W(1), .DWELL(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel),
        .hold(hold), .dout(dout), .ch(ch), .ch_chg(ch_chg)
    );

    mux_scan #(.CH_NUM(3), .DATA_W(1), .DWELL(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .mode(mode3), .sel(sel3),
        .hold(hold3), .dout(dout3), .ch(ch3), .ch_chg(ch_chg3)
    );

    typedef struct {
        logic       mode;
        logic       hold;
        logic [1:0] sel;
        logic [1:0] ch;
        logic       dout;
        logic       chg;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic m, input logic h, input logic [1:0] s,
                                input logic [1:0] c, input logic d, input logic g);
        vec_t v;
        v.mode = m; v.hold = h; v.sel = s; v.ch = c; v.dout = d; v.chg = g;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // manual select sequence 0 -> 2 -> 1 -> 3, each held 5 edges
        for (int i = 0; i < 5; i++) add(0, 0, 2'd0, 2'd0, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 2'd2, 2'd2, 1, i == 0);
        for (int i = 0; i < 5; i++) add(0, 0, 2'd1, 2'd1, 0, i == 0);
        for (int i = 0; i < 5; i++) add(0, 0, 2'd3, 2'd3, 0, i == 0);
        add(0, 0, 2'd0, 2'd0, 1, 1);
        // scan from ch0 for 20 edges (sel ignored): wraps 3->0, ends ch2 count 1
        for (int i = 0; i < 20; i++) begin
            logic [1:0] c;
            c = 2'((i / 3) % 4);
            add(1, 0, 2'd2, c, ~c[0], (i > 0) && (i % 3 == 0));
        end
        // pause 5 edges, then ch2 for 2 more edges, then ch3
        for (int i = 0; i < 5; i++) add(1, 1, 2'd0, 2'd2, 1, 0);
        add(1, 0, 2'd0, 2'd2, 1, 0);
        add(1, 0, 2'd0, 2'd2, 1, 0);
        add(1, 0, 2'd0, 2'd3, 0, 1);
        // manual ignores hold; reloading same value gives no pulse
        add(0, 1, 2'd1, 2'd1, 0, 1);
        add(0, 1, 2'd2, 2'd2, 1, 1);
        add(0, 1, 2'd2, 2'd2, 1, 0);
        // mode switch out of scan at ch1 count 2, then back in at ch3
        add(0, 0, 2'd1, 2'd1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 2'd0, 2'd1, 0, 0);
        add(0, 0, 2'd3, 2'd3, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 2'd3, 2'd3, 0, 0);
        add(1, 0, 2'd3, 2'd0, 1, 1);

        din = 4'b0101; din3 = 3'b101;
        mode = 0; hold = 0; sel = 2'd0;
        mode3 = 0; hold3 = 0; sel3 = 2'd0;
        rst_n = 1'b0;
        #12;
        chk("rst_ch", 0, ch, 0);
        chk("rst_dout", 0, dout, 0);
        chk("rst_chg", 0, ch_chg, 0);
        chk("rst_ch3", 0, ch3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            mode = vq[i].mode; hold = vq[i].hold; sel = vq[i].sel;
            step();
            chk("vec_ch", i, ch, vq[i].ch);
            chk("vec_dout", i, dout, vq[i].dout);
            chk("vec_chg", i, ch_chg, vq[i].chg);
        end

        // async reset while scanning at ch2
        mode = 0; sel = 2'd2; step();
        mode = 1; step();
        chk("pre_rst_ch", 0, ch, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("async_ch", 0, ch, 0);
        chk("async_dout", 0, dout, 0);
        chk("async_chg", 0, ch_chg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_ch", i, ch, 0);
            chk("post_rst_dout", i, dout, 1);
        end
        step();
        chk("post_rst_adv", 0, ch, 1);
        chk("post_rst_chg", 0, ch_chg, 1);

        // 3-channel instance: out-of-range select and non-power-of-two wrap
        sel3 = 2'd2; step();
        chk("c3_sel2", 0, ch3, 2);
        chk("c3_sel2_chg", 0, ch_chg3, 1);
        chk("c3_sel2_dout", 0, dout3, 1);
        sel3 = 2'd3;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("c3_bad_ch", i, ch3, 2);
            chk("c3_bad_chg", i, ch_chg3, 0);
        end
        mode3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("c3_scan_ch", i, ch3, 2);
        end
        step();
        chk("c3_wrap_ch", 0, ch3, 0);
        chk("c3_wrap_chg", 0, ch_chg3, 1);
        chk("c3_wrap_dout", 0, dout3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
